// File: rtl/sub_nibble_rx.sv
// Nibble-stream receiver: assembles Sub nibbles into 16-bit words, buffers
// them in a first-word-fall-through FIFO and drives registered backpressure.
module sub_nibble_rx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_nib,
  input  logic [2:0]  in_tag,
  input  logic        in_last,
  input  logic        in_err,
  output logic        in_hold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [2:0]  out_tag,
  output logic [2:0]  out_len,
  output logic        out_err,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 23;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      state, state_nxt;
  logic [15:0] acc_word, word_nxt;
  logic [2:0]  acc_tag, tag_nxt;
  logic [2:0]  acc_len, len_nxt;
  logic        acc_err, err_nxt;
  logic [7:0]  gap, gap_nxt;
  logic        push;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] last_q, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full, pop, wr_en, drop;

  // Next-state and word assembly; push fires on the edge sampling the completing nibble
  always_comb begin
    state_nxt = state;
    word_nxt  = acc_word;
    tag_nxt   = acc_tag;
    len_nxt   = acc_len;
    err_nxt   = acc_err;
    gap_nxt   = gap;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          word_nxt = {12'h000, in_nib};
          tag_nxt  = in_tag;
          len_nxt  = 3'd1;
          err_nxt  = in_err;
          gap_nxt  = '0;
          if (in_last) push = 1'b1;
          else         state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          case (acc_len[1:0])
            2'd1:    word_nxt[7:4]   = in_nib;
            2'd2:    word_nxt[11:8]  = in_nib;
            default: word_nxt[15:12] = in_nib;
          endcase
          len_nxt = acc_len + 3'd1;
          err_nxt = acc_err | in_err | (in_tag != acc_tag);
          gap_nxt = '0;
          if (in_last || len_nxt == 3'd4) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (gap == 8'(TIMEOUT - 1)) begin
          push      = 1'b1;
          err_nxt   = 1'b1;
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Partial-word accumulator and idle-gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_word <= '0;
      acc_tag  <= '0;
      acc_len  <= '0;
      acc_err  <= 1'b0;
      gap      <= '0;
    end else begin
      acc_word <= word_nxt;
      acc_tag  <= tag_nxt;
      acc_len  <= len_nxt;
      acc_err  <= err_nxt;
      gap      <= gap_nxt;
    end
  end

  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Occupancy after this edge
  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + (AW+1)'(1);
    else if (!wr_en && pop) count_nxt = count - (AW+1)'(1);
  end

  // FIFO storage; entries are only read while occupied, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {word_nxt, tag_nxt, len_nxt, err_nxt};
  end

  // FIFO pointers, occupancy, last-popped entry, backpressure and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_q   <= '0;
      in_hold  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      count   <= count_nxt;
      in_hold <= (count_nxt >= (AW+1)'(DEPTH - 1));
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // When empty, the outputs hold the most recently popped entry
  assign head = out_valid ? mem[rd_ptr] : last_q;
  assign {out_word, out_tag, out_len, out_err} = head;

endmodule

// File: tb/tb_sub_nibble_rx.sv
// Self-checking bench for sub_nibble_rx: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_sub_nibble_rx;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_nib;
  logic [2:0]  in_tag;
  logic        in_last;
  logic        in_err;
  logic        in_hold;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [2:0]  out_tag;
  logic [2:0]  out_len;
  logic        out_err;
  logic [7:0]  drop_cnt;

  sub_nibble_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_nib(in_nib),
    .in_tag(in_tag), .in_last(in_last), .in_err(in_err), .in_hold(in_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_tag(out_tag), .out_len(out_len), .out_err(out_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [2:0]  t;
    logic [2:0]  l;
    logic        e;
  } ent_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  int          m_nibs[$];
  ent_t        m_fifo[$];
  ent_t        m_last;
  logic [2:0]  m_tag;
  logic        m_err;
  int unsigned m_gap;
  logic [7:0]  m_drop;
  logic        m_hold;

  task automatic model_reset();
    m_nibs.delete();
    m_fifo.delete();
    m_last = '{16'h0, 3'h0, 3'h0, 1'b0};
    m_tag  = '0;
    m_err  = 1'b0;
    m_gap  = 0;
    m_drop = '0;
    m_hold = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] n, input logic [2:0] t,
                            input logic l, input logic e, input logic r);
    bit          pop, done;
    ent_t        c;
    int unsigned word;
    pop  = (m_fifo.size() != 0) && r;
    done = 0;
    c    = '{16'h0, 3'h0, 3'h0, 1'b0};
    if (v) begin
      if (m_nibs.size() == 0) begin
        m_tag = t;
        m_err = e;
      end else begin
        m_err = m_err | e | (t != m_tag);
      end
      m_nibs.push_back(int'(n));
      m_gap = 0;
      if (l || m_nibs.size() == 4) done = 1;
    end else if (m_nibs.size() != 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        done  = 1;
        m_err = 1'b1;
      end
    end
    if (done) begin
      word = 0;
      foreach (m_nibs[i]) word += m_nibs[i] * (1 << (4 * i));
      c.w = word[15:0];
      c.t = m_tag;
      c.l = 3'(m_nibs.size());
      c.e = m_err;
      m_nibs.delete();
      m_gap = 0;
    end
    if (pop) m_last = m_fifo.pop_front();
    if (done) begin
      if (m_fifo.size() == DEPTH) m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
      else                        m_fifo.push_back(c);
    end
    m_hold = (m_fifo.size() >= DEPTH - 1);
  endtask

  function automatic ent_t exp_head();
    return (m_fifo.size() != 0) ? m_fifo[0] : m_last;
  endfunction

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge
  task automatic cycle(input logic v, input logic [3:0] n, input logic [2:0] t,
                       input logic l, input logic e, input logic r);
    in_valid  = v;
    in_nib    = n;
    in_tag    = t;
    in_last   = l;
    in_err    = e;
    out_ready = r;
    model_step(v, n, t, l, e, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_nib = 0; in_tag = 0; in_last = 0; in_err = 0; out_ready = 0;
    model_reset();
    #12;
    n_vec++;
    if ({out_valid, out_word, out_tag, out_len, out_err, in_hold, drop_cnt} !== 33'h0) begin
      n_bad++;
      $display("FAIL reset: got %h want %h",
               {out_valid, out_word, out_tag, out_len, out_err, in_hold, drop_cnt}, 33'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    for (int i = 1; i <= 4; i++) cycle(1, 4'(i), 3'd5, 0, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_tag, out_len, out_err} !== {1'b1, 16'h4321, 3'd5, 3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL full_word: got %h want %h",
               {out_valid, out_word, out_tag, out_len, out_err}, {1'b1, 16'h4321, 3'd5, 3'd4, 1'b0});
    end
  endtask

  task automatic test_last_early();
    cycle(1, 4'hA, 3'd1, 0, 0, 1);
    cycle(1, 4'hB, 3'd1, 1, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_len, out_err} !== {1'b1, 16'h00BA, 3'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL last_early: got %h want %h",
               {out_valid, out_word, out_len, out_err}, {1'b1, 16'h00BA, 3'd2, 1'b0});
    end
  endtask

  task automatic test_timeout();
    cycle(1, 4'h7, 3'd0, 0, 0, 1);
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0, 0, 1);
    n_vec++;
    if ({out_valid, out_word} !== {1'b0, 16'h00BA}) begin
      n_bad++;
      $display("FAIL timeout_early: got %h want %h", {out_valid, out_word}, {1'b0, 16'h00BA});
    end
    cycle(0, 0, 0, 0, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_len, out_err} !== {1'b1, 16'h0007, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_flush: got %h want %h",
               {out_valid, out_word, out_len, out_err}, {1'b1, 16'h0007, 3'd1, 1'b1});
    end
    cycle(1, 4'h3, 3'd0, 0, 0, 1);
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL gap14_noflush: got %b want 0", out_valid);
    end
    cycle(1, 4'h5, 3'd0, 1, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_len, out_err} !== {1'b1, 16'h0053, 3'd2, 1'b0}) begin
      n_bad++;
      $display("FAIL gap14_word: got %h want %h",
               {out_valid, out_word, out_len, out_err}, {1'b1, 16'h0053, 3'd2, 1'b0});
    end
  endtask

  task automatic test_overflow();
    logic [3:0] order [4];
    order[0] = 4'd2; order[1] = 4'd3; order[2] = 4'd4; order[3] = 4'd6;
    cycle(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 4'(k), 3'd1, 1, 0, 0);
      if (k == 2 || k == 3) begin
        n_vec++;
        if (in_hold !== (k == 3)) begin
          n_bad++;
          $display("FAIL hold_after_%0d: got %b want %b", k, in_hold, (k == 3));
        end
      end
    end
    n_vec++;
    if (drop_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL drop_one: got %0d want 1", drop_cnt);
    end
    // full FIFO, simultaneous pop and push: nothing dropped
    cycle(1, 4'd6, 3'd1, 1, 0, 1);
    n_vec++;
    if ({drop_cnt, out_word} !== {8'd1, 16'h0002}) begin
      n_bad++;
      $display("FAIL full_pop_push: got %h want %h", {drop_cnt, out_word}, {8'd1, 16'h0002});
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({out_valid, out_word} !== {1'b1, 12'h000, order[k]}) begin
        n_bad++;
        $display("FAIL drain_%0d: got %h want %h", k, {out_valid, out_word}, {1'b1, 12'h000, order[k]});
      end
      cycle(0, 0, 0, 0, 0, 1);
    end
    n_vec++;
    if ({out_valid, in_hold} !== 2'b00) begin
      n_bad++;
      $display("FAIL drained: got %b want 00", {out_valid, in_hold});
    end
  endtask

  task automatic test_tag_err();
    cycle(1, 4'h1, 3'd2, 0, 0, 1);
    cycle(1, 4'h2, 3'd3, 1, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_tag, out_len, out_err} !== {1'b1, 16'h0021, 3'd2, 3'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL tag_mismatch: got %h want %h",
               {out_valid, out_word, out_tag, out_len, out_err}, {1'b1, 16'h0021, 3'd2, 3'd2, 1'b1});
    end
    cycle(1, 4'hC, 3'd1, 0, 0, 1);
    cycle(1, 4'hD, 3'd1, 0, 0, 1);
    cycle(1, 4'hE, 3'd1, 0, 0, 1);
    cycle(1, 4'hF, 3'd1, 0, 1, 1);
    n_vec++;
    if ({out_valid, out_word, out_tag, out_len, out_err} !== {1'b1, 16'hFEDC, 3'd1, 3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL in_err_last: got %h want %h",
               {out_valid, out_word, out_tag, out_len, out_err}, {1'b1, 16'hFEDC, 3'd1, 3'd4, 1'b1});
    end
  endtask

  task automatic test_reset_midword();
    cycle(1, 4'h1, 3'd0, 0, 0, 1);
    cycle(1, 4'h2, 3'd0, 0, 0, 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    n_vec++;
    if ({out_valid, out_word, drop_cnt, in_hold} !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want 0", {out_valid, out_word, drop_cnt, in_hold});
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 9; i >= 6; i--) cycle(1, 4'(i), 3'd4, 0, 0, 1);
    n_vec++;
    if ({out_valid, out_word, out_tag, out_len, out_err, drop_cnt} !==
        {1'b1, 16'h6789, 3'd4, 3'd4, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL fresh_word: got %h want %h", {out_valid, out_word, out_tag, out_len, out_err, drop_cnt},
               {1'b1, 16'h6789, 3'd4, 3'd4, 1'b0, 8'd0});
    end
  endtask

  task automatic test_random();
    ent_t        h;
    logic [32:0] got, want;
    int unsigned pv, pr;
    for (int ph = 0; ph < 8; ph++) begin
      pv = (ph % 2 == 0) ? 85 : 8;
      pr = (ph % 4 < 2) ? 30 : 90;
      for (int i = 0; i < 300; i++) begin
        cycle($urandom_range(0, 99) < pv, 4'($urandom),
              ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd5,
              $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 99) < pr);
        h    = exp_head();
        want = {m_fifo.size() != 0, h.w, h.t, h.l, h.e, m_hold, m_drop};
        got  = {out_valid, out_word, out_tag, out_len, out_err, in_hold, drop_cnt};
        n_vec++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL random ph%0d cyc%0d: got %h want %h", ph, i, got, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_last_early();
    test_timeout();
    test_overflow();
    test_tag_err();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_nibble_rx.md
Name: sub_nibble_rx

Overview:
- Receiving end of the Sub output bundle.
- Sub drives a nibble stream: valid strobe, 4-bit data, 3-bit tag, last marker and error marker.
- This block assembles the nibbles into 16-bit words, buffers the words in a small FIFO, presents them on a ready/valid interface, and drives a hold (backpressure) signal back to the producer.
- It sits next to each Sub instance, between Sub and the downstream consumer.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, at least 2).
- TIMEOUT, 15, idle cycles allowed mid-word before a partial word is flushed (1..255).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  nibble strobe from Sub.
- in_nib  input  4  nibble data, LSB-first within a word.
- in_tag  input  3  stream tag; sampled on the first nibble of a word.
- in_last  input  1  marks the final nibble of a word; qualified by in_valid.
- in_err  input  1  producer error; qualified by in_valid.
- in_hold  output  1  backpressure request to Sub.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the FIFO head.
- out_word  output  16  assembled word; unfilled nibbles are zero.
- out_tag  output  3  tag of the word.
- out_len  output  3  number of nibbles in the word, 1..4.
- out_err  output  1  word error flag.
- drop_cnt  output  8  count of words dropped on overflow; saturates at 255.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM to IDLE; FIFO empty.
  - out_valid=0, out_word=0, out_tag=0, out_len=0, out_err=0.
  - in_hold=0, drop_cnt=0, gap counter=0, partial word discarded.
  - Reset mid-word loses the partial word with no output.
- FSM states: IDLE and COLLECT.
  - IDLE, in_valid=1: load nibble 0, latch in_tag, len=1, err=in_err. If in_last=1, the word completes immediately; otherwise go to COLLECT.
  - COLLECT, in_valid=1: place the nibble at index len, len+1, OR in in_err.
    - If in_tag differs from the latched tag, set err; the latched tag is kept.
    - The word completes when len reaches 4 or in_last=1; the FSM then returns to IDLE.
  - COLLECT, in_valid=0: gap counter increments; it clears on any in_valid.
    - When the counter reaches TIMEOUT, the partial word completes with err forced to 1; the FSM returns to IDLE.
- Completion pushes {word, tag, len, err} into the FIFO at the same clock edge that samples the completing nibble.
- Latency: with the FIFO empty, out_valid=1 in the cycle after the completing nibble.
- FIFO is first-word-fall-through:
  - Pop occurs when out_valid && out_ready.
  - Outputs are stable while out_valid && !out_ready.
  - When the FIFO is empty, out_word/out_tag/out_len/out_err keep their last values.
- Full FIFO:
  - A completion with the FIFO full and no pop in the same cycle drops the word; drop_cnt increments, saturating at 255.
  - Simultaneous pop and push when full: both take effect; nothing is dropped.
  - Push while empty and out_ready=1: the word still appears for at least one cycle.
- in_hold is registered: 1 when the FIFO occupancy after the current edge is >= DEPTH-1, else 0.
- Sub may ignore in_hold for one cycle; that margin is covered by the last free entry.
- in_valid arriving in the same cycle as the timeout: the nibble belongs to the current word and no timeout fires.

Test Plan:
- Four nibbles 1,2,3,4 with in_tag=5, out_ready=1 -> one cycle after nibble 4: out_valid=1, out_word=0x4321, out_tag=5, out_len=4, out_err=0.
- Nibbles A,B with in_last on B -> out_word=0x00BA, out_len=2, out_err=0; FSM back in IDLE.
- Nibble 7 then in_valid low for 15 cycles -> out_word=0x0007, out_len=1, out_err=1; a gap of 14 cycles followed by a nibble flushes nothing.
- out_ready=0 with 5 complete words, DEPTH=4 -> in_hold=1 after the 3rd push; 5th word dropped, drop_cnt=1; draining returns words 1-4 in order and in_hold falls.
- Tag 2 on nibble 0 and tag 3 on nibble 1 -> out_tag=2, out_err=1; in_err on nibble 3 of a clean word -> out_err=1.
- rst_n low after 2 nibbles, then 4 fresh nibbles -> only the fresh word is output, with len=4; drop_cnt=0.
